output_sender: RTL and testbench

- Downstream stage of the processing core. On start_sending from the fsm, it reads result words from the on-chip output memory and streams them off-chip over data_out.
- Each word is split into HIGH_SPEED_OUT_PINS-wide chunks. Every chunk is sent with a 4-phase out_request/in_acknowledge handshake.
- When the last chunk's handshake completes, it pulses done_sending back to the fsm.

---
 rtl/output_sender.sv | 174 +++++++++++++++++
 tb/tb_output_sender.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_sender.sv
// Streams result-memory words off-chip as PINS-wide chunks, LSB chunk first,
// one 4-phase out_request/in_acknowledge handshake per chunk.
module output_sender #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int HIGH_SPEED_OUT_PINS = 8,
    parameter int ADDRESS_WIDTH       = 8
) (
    input  logic                           clk,
    input  logic                           rst_async_n,
    input  logic                           start_sending,
    input  logic [ADDRESS_WIDTH-1:0]       num_words,
    output logic                           mem_read_enable,
    output logic [ADDRESS_WIDTH-1:0]       mem_address,
    input  logic [WORD_BIT_WIDTH-1:0]      mem_read_data,
    output logic [HIGH_SPEED_OUT_PINS-1:0] data_out,
    output logic                           out_request,
    input  logic                           in_acknowledge,
    output logic                           busy,
    output logic                           done_sending
);

    localparam int CHUNKS = WORD_BIT_WIDTH / HIGH_SPEED_OUT_PINS;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH       = 3'd1,
        S_CAPTURE     = 3'd2,
        S_SETUP       = 3'd3,
        S_WAIT_ACK_HI = 3'd4,
        S_WAIT_ACK_LO = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t                           state_q;
    logic                             ack_meta_q;
    logic                             ack_sync_q;
    logic                             armed_q;
    logic [ADDRESS_WIDTH-1:0]         last_word_q;
    logic [ADDRESS_WIDTH-1:0]         word_cnt_q;
    logic [CW-1:0]                    chunk_cnt_q;
    logic [WORD_BIT_WIDTH-1:0]        shift_q;
    logic                             mem_read_enable_q;
    logic [ADDRESS_WIDTH-1:0]         mem_address_q;
    logic [HIGH_SPEED_OUT_PINS-1:0]   data_out_q;
    logic                             out_request_q;
    logic                             busy_q;
    logic                             done_q;

    logic [WORD_BIT_WIDTH-1:0]        shift_d;
    logic [ADDRESS_WIDTH-1:0]         word_cnt_d;
    logic [CW-1:0]                    chunk_cnt_d;

    // Next-chunk and next-word values used by the sequencer.
    always_comb begin
        shift_d     = shift_q >> HIGH_SPEED_OUT_PINS;
        word_cnt_d  = word_cnt_q + ADDRESS_WIDTH'(1);
        chunk_cnt_d = chunk_cnt_q + CW'(1);
    end

    // Two-flop synchroniser for the off-chip acknowledge.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= in_acknowledge;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Transfer sequencer: state, counters and every registered output.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q           <= S_IDLE;
            armed_q           <= 1'b0;
            last_word_q       <= {ADDRESS_WIDTH{1'b0}};
            word_cnt_q        <= {ADDRESS_WIDTH{1'b0}};
            chunk_cnt_q       <= {CW{1'b0}};
            shift_q           <= {WORD_BIT_WIDTH{1'b0}};
            mem_read_enable_q <= 1'b0;
            mem_address_q     <= {ADDRESS_WIDTH{1'b0}};
            data_out_q        <= {HIGH_SPEED_OUT_PINS{1'b0}};
            out_request_q     <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            // An ack left high from before the start must drop before it can count.
            if ((state_q != S_IDLE) && !ack_sync_q) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_sending) begin
                        armed_q <= 1'b0;
                        if (num_words == {ADDRESS_WIDTH{1'b0}}) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            last_word_q       <= num_words - ADDRESS_WIDTH'(1);
                            word_cnt_q        <= {ADDRESS_WIDTH{1'b0}};
                            chunk_cnt_q       <= {CW{1'b0}};
                            mem_read_enable_q <= 1'b1;
                            mem_address_q     <= {ADDRESS_WIDTH{1'b0}};
                            busy_q            <= 1'b1;
                            state_q           <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    mem_read_enable_q <= 1'b0;
                    state_q           <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    shift_q     <= mem_read_data;
                    data_out_q  <= mem_read_data[HIGH_SPEED_OUT_PINS-1:0];
                    chunk_cnt_q <= {CW{1'b0}};
                    state_q     <= S_SETUP;
                end
                S_SETUP: begin
                    out_request_q <= 1'b1;
                    state_q       <= S_WAIT_ACK_HI;
                end
                S_WAIT_ACK_HI: begin
                    if (ack_sync_q && armed_q) begin
                        out_request_q <= 1'b0;
                        state_q       <= S_WAIT_ACK_LO;
                    end
                end
                S_WAIT_ACK_LO: begin
                    if (!ack_sync_q) begin
                        if (chunk_cnt_q != LAST_CHUNK) begin
                            chunk_cnt_q <= chunk_cnt_d;
                            shift_q     <= shift_d;
                            data_out_q  <= shift_d[HIGH_SPEED_OUT_PINS-1:0];
                            state_q     <= S_SETUP;
                        end else if (word_cnt_q != last_word_q) begin
                            word_cnt_q        <= word_cnt_d;
                            mem_read_enable_q <= 1'b1;
                            mem_address_q     <= word_cnt_d;
                            state_q           <= S_FETCH;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_request_q     <= 1'b0;
                    mem_read_enable_q <= 1'b0;
                    busy_q            <= 1'b0;
                    done_q            <= 1'b0;
                    state_q           <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_read_enable = mem_read_enable_q;
    assign mem_address     = mem_address_q;
    assign data_out        = data_out_q;
    assign out_request     = out_request_q;
    assign busy            = busy_q;
    assign done_sending    = done_q;

endmodule

// File: tb/tb_output_sender.sv
// Directed bench for output_sender: memory model, auto/manual receiver,
// a handshake monitor and one task per scenario.
module tb_output_sender;

    localparam int AW = 8;
    localparam int WW = 32;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_async_n = 1'b0;
    logic          start_sending = 1'b0;
    logic [AW-1:0] num_words = 8'd0;
    logic          mem_read_enable;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_read_data = 32'd0;
    logic [PW-1:0] data_out;
    logic          out_request;
    logic          in_acknowledge;
    logic          busy;
    logic          done_sending;

    logic          rx_auto = 1'b1;
    logic          ack_man = 1'b0;
    logic          ack_auto = 1'b0;
    int            ack_dly = 2;
    int            rx_cnt = 0;
    logic [WW-1:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    logic [PW-1:0] chunks [$];
    logic [AW-1:0] rd_addr [$];
    int            rd_rise [$];
    int            rises = 0;
    int            falls = 0;
    int            dones = 0;
    int            viol = 0;
    logic          prev_req = 1'b0;
    logic          prev_re = 1'b0;
    logic [PW-1:0] prev_data = 8'd0;

    output_sender #(
        .WORD_BIT_WIDTH(WW), .HIGH_SPEED_OUT_PINS(PW), .ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_async_n(rst_async_n), .start_sending(start_sending),
        .num_words(num_words), .mem_read_enable(mem_read_enable),
        .mem_address(mem_address), .mem_read_data(mem_read_data),
        .data_out(data_out), .out_request(out_request),
        .in_acknowledge(in_acknowledge), .busy(busy), .done_sending(done_sending)
    );

    always #5 clk = ~clk;

    assign in_acknowledge = rx_auto ? ack_auto : ack_man;

    // Synchronous-read result memory.
    always @(posedge clk) begin
        if (mem_read_enable) mem_read_data <= mem[mem_address];
    end

    // Receiver: mirrors out_request onto ack after ack_dly cycles.
    always @(negedge clk) begin
        if (out_request != ack_auto) begin
            if (rx_cnt + 1 >= ack_dly) begin
                ack_auto <= out_request;
                rx_cnt   <= 0;
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end else begin
            rx_cnt <= 0;
        end
    end

    // Monitor: chunk log, handshake edges, reads and protocol violations.
    always @(negedge clk) begin
        if (!rst_async_n) begin
            prev_req  <= 1'b0;
            prev_re   <= 1'b0;
            prev_data <= 8'd0;
        end else begin
            if (out_request && !prev_req) begin
                chunks.push_back(data_out);
                rises <= rises + 1;
                if (data_out !== prev_data) viol <= viol + 1;
            end
            if (!out_request && prev_req) falls <= falls + 1;
            if ((data_out !== prev_data) && (out_request || prev_req)) viol <= viol + 1;
            if (mem_read_enable) begin
                rd_addr.push_back(mem_address);
                rd_rise.push_back(rises);
                if (prev_re) viol <= viol + 1;
            end
            if (done_sending) dones <= dones + 1;
            prev_req  <= out_request;
            prev_re   <= mem_read_enable;
            prev_data <= data_out;
        end
    end

    task automatic pulse_start(input logic [AW-1:0] n);
        @(posedge clk); #1;
        start_sending = 1'b1;
        num_words     = n;
        @(posedge clk); #1;
        start_sending = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_sending) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done got=timeout exp=done within %0d cycles", name, budget);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_async_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_request !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", out_request); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done_sending !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_sending); end
        checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", mem_read_enable); end
        checks++; if (mem_address !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mem_address); end
        rst_async_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [PW-1:0] exp_b [4];
        int cb, rb, fb, db, ab, vb;
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        mem[0] = 32'hA1B2C3D4;
        ack_dly = 2;
        cb = chunks.size(); rb = rises; fb = falls; db = dones; ab = rd_addr.size(); vb = viol;
        pulse_start(8'd1);
        wait_done(300, "single");
        repeat (3) @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (chunks.size() <= cb + k || chunks[cb + k] !== exp_b[k]) begin
                failures++;
                $display("FAIL single_chunk%0d got=%h exp=%h", k,
                         (chunks.size() > cb + k) ? chunks[cb + k] : 8'hxx, exp_b[k]);
            end
        end
        checks++; if (rises - rb != 4) begin failures++; $display("FAIL single_rises got=%0d exp=4", rises - rb); end
        checks++; if (falls - fb != 4) begin failures++; $display("FAIL single_falls got=%0d exp=4", falls - fb); end
        checks++; if (dones - db != 1) begin failures++; $display("FAIL single_dones got=%0d exp=1", dones - db); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
        checks++; if (rd_addr.size() - ab != 1) begin failures++; $display("FAIL single_reads got=%0d exp=1", rd_addr.size() - ab); end
        checks++; if (viol != vb) begin failures++; $display("FAIL single_protocol got=%0d violations exp=0", viol - vb); end
    endtask

    task automatic test_fetch_timing();
        int cb, rb, ab, vb;
        logic [PW-1:0] e;
        for (int i = 0; i < 3; i++) mem[i] = i;
        cb = chunks.size(); rb = rises; ab = rd_addr.size(); vb = viol;
        pulse_start(8'd3);
        wait_done(600, "fetch");
        repeat (3) @(negedge clk); #1;
        checks++; if (chunks.size() - cb != 12) begin failures++; $display("FAIL fetch_chunks got=%0d exp=12", chunks.size() - cb); end
        checks++; if (rd_addr.size() - ab != 3) begin failures++; $display("FAIL fetch_reads got=%0d exp=3", rd_addr.size() - ab); end
        for (int k = 0; k < 12 && cb + k < chunks.size(); k++) begin
            e = ((k % 4) == 0) ? PW'(k / 4) : 8'h00;
            checks++;
            if (chunks[cb + k] !== e) begin failures++; $display("FAIL fetch_chunk%0d got=%h exp=%h", k, chunks[cb + k], e); end
        end
        for (int i = 0; i < 3 && ab + i < rd_addr.size(); i++) begin
            checks++;
            if (rd_addr[ab + i] !== AW'(i)) begin failures++; $display("FAIL fetch_addr%0d got=%0d exp=%0d", i, rd_addr[ab + i], i); end
            checks++;
            if (rd_rise[ab + i] - rb != 4 * i) begin failures++; $display("FAIL fetch_order%0d got=%0d prior chunks exp=%0d", i, rd_rise[ab + i] - rb, 4 * i); end
        end
        checks++; if (viol != vb) begin failures++; $display("FAIL fetch_protocol got=%0d violations exp=0", viol - vb); end
    endtask

    task automatic test_zero_length();
        int rb, ab, db;
        rb = rises; ab = rd_addr.size(); db = dones;
        pulse_start(8'd0);
        @(negedge clk);
        checks++; if (done_sending !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done_sending); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (done_sending !== 1'b0) begin failures++; $display("FAIL zero_pulse got=%b exp=0", done_sending); end
        repeat (5) @(negedge clk); #1;
        checks++; if (dones - db != 1) begin failures++; $display("FAIL zero_dones got=%0d exp=1", dones - db); end
        checks++; if (rd_addr.size() != ab) begin failures++; $display("FAIL zero_reads got=%0d exp=0", rd_addr.size() - ab); end
        checks++; if (rises != rb) begin failures++; $display("FAIL zero_req got=%0d exp=0", rises - rb); end
    endtask

    task automatic test_slow_receiver();
        int bad, vb;
        bit seen = 1'b0;
        mem[0] = 32'h11223344;
        rx_auto = 1'b0; ack_man = 1'b0; vb = viol;
        pulse_start(8'd1);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (out_request) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL slow_req got=0 exp=1 within 30 cycles"); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_request !== 1'b1 || data_out !== 8'h44) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL slow_hold_lo got=%0d unstable cycles exp=0", bad); end
        ack_man = 1'b1; bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (data_out !== 8'h44) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL slow_hold_hi got=%0d data changes exp=0", bad); end
        checks++; if (out_request !== 1'b0) begin failures++; $display("FAIL slow_req_fall got=%b exp=0", out_request); end
        ack_man = 1'b0;
        @(negedge clk);
        checks++; if (data_out !== 8'h44) begin failures++; $display("FAIL slow_sync1 got=%h exp=44", data_out); end
        @(negedge clk);
        checks++; if (data_out !== 8'h44) begin failures++; $display("FAIL slow_sync2 got=%h exp=44", data_out); end
        @(negedge clk);
        checks++; if (data_out !== 8'h33) begin failures++; $display("FAIL slow_next got=%h exp=33", data_out); end
        rx_auto = 1'b1;
        wait_done(300, "slow");
        checks++; if (viol != vb) begin failures++; $display("FAIL slow_protocol got=%0d violations exp=0", viol - vb); end
    endtask

    task automatic test_spurious();
        int cb, db, ab, bad;
        rx_auto = 1'b0; ack_man = 1'b1; bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_request !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL spur_idle_ack got=%0d active cycles exp=0", bad); end
        ack_man = 1'b0;
        repeat (4) @(negedge clk);
        rx_auto = 1'b1;
        mem[0] = 32'hDEADBEEF; mem[1] = 32'h01234567;
        cb = chunks.size(); db = dones; ab = rd_addr.size();
        pulse_start(8'd2);
        repeat (15) @(negedge clk);
        pulse_start(8'd3);
        wait_done(600, "spur");
        repeat (10) @(negedge clk); #1;
        checks++; if (chunks.size() - cb != 8) begin failures++; $display("FAIL spur_chunks got=%0d exp=8", chunks.size() - cb); end
        checks++; if (rd_addr.size() - ab != 2) begin failures++; $display("FAIL spur_reads got=%0d exp=2", rd_addr.size() - ab); end
        checks++; if (dones - db != 1) begin failures++; $display("FAIL spur_dones got=%0d exp=1", dones - db); end
        checks++;
        if (chunks.size() < cb + 8 || chunks[cb + 7] !== 8'h01) begin
            failures++; $display("FAIL spur_last_chunk got=%h exp=01", (chunks.size() > 0) ? chunks[chunks.size() - 1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] exp_b [4];
        int ab, db, cb;
        bit seen = 1'b0;
        exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        mem[0] = 32'h55667788; mem[1] = 32'h99AABBCC;
        ack_dly = 6; ab = rd_addr.size(); db = dones;
        pulse_start(8'd2);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (rd_addr.size() - ab >= 2 && out_request) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstmid_reach got=timeout exp=word1 request"); end
        #2 rst_async_n = 1'b0;
        #1;
        checks++; if (out_request !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", out_request); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        rst_async_n = 1'b1;
        repeat (20) @(negedge clk); #1;
        checks++; if (dones != db) begin failures++; $display("FAIL rstmid_nodone got=%0d exp=0", dones - db); end
        mem[0] = 32'hCAFEF00D; ack_dly = 2;
        cb = chunks.size(); db = dones;
        pulse_start(8'd1);
        wait_done(300, "rstmid_after");
        repeat (3) @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (chunks.size() <= cb + k || chunks[cb + k] !== exp_b[k]) begin
                failures++;
                $display("FAIL rstmid_chunk%0d got=%h exp=%h", k,
                         (chunks.size() > cb + k) ? chunks[cb + k] : 8'hxx, exp_b[k]);
            end
        end
        checks++; if (dones - db != 1) begin failures++; $display("FAIL rstmid_after_dones got=%0d exp=1", dones - db); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        test_reset();
        test_single_word();
        test_fetch_timing();
        test_zero_length();
        test_slow_receiver();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
